// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus bundle: imem request/response channel, decode handoff and EX redirect.
// master = fetch controller view, slave = environment (imem, decode, EX) view.
interface if_fetch_ctrl_if;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    input  redirect, redirect_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_pc4
  );

  modport slave (
    output redirect, redirect_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_pc4
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one outstanding imem request at a time,
// buffers the returned instruction for decode and flushes in-flight fetches on redirect.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] target;
  logic        unused_addr_lsbs;

  assign target           = {bus.redirect_addr[31:2], 2'b00};
  assign unused_addr_lsbs = ^bus.redirect_addr[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      inst_q   <= inst_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    inst_d   = inst_q;

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (bus.redirect) pc_d = target;
        if (bus.imem_req_ready) begin
          if (bus.redirect) begin
            state_d = DRAIN;
          end else begin
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
      end

      WAIT: begin
        if (bus.redirect) begin
          // A response arriving with the redirect is the stale one, so no drain is needed.
          pc_d    = target;
          state_d = bus.imem_rsp_valid ? REQ : DRAIN;
        end else if (bus.imem_rsp_valid) begin
          inst_d  = bus.imem_rsp_data;
          pc_d    = req_pc_q + 32'd4;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          pc_d    = target;
          state_d = REQ;
        end else if (bus.if_ready) begin
          state_d = REQ;
        end
      end

      DRAIN: begin
        if (bus.redirect) pc_d = target;
        if (bus.imem_rsp_valid) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = (state_q == HOLD) && !bus.redirect;
  assign bus.if_inst        = inst_q;
  assign bus.if_pc          = req_pc_q;
  assign bus.if_pc4         = req_pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: stimulus pushes expected requests and decode handoffs
// into queues that a negedge monitor pops; a second instance covers the wrapping reset PC.
module tb_if_fetch_ctrl;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } dec_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] req_q[$];
  dec_t        dec_q[$];

  if_fetch_ctrl_if bus0 ();
  if_fetch_ctrl_if bus1 ();

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for dut0: every accepted request and every decode handoff must match.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.imem_req_valid && bus0.imem_req_ready) begin
        if (req_q.size() == 0) check("unexpected_req", bus0.imem_req_addr, 32'hxxxx_xxxx);
        else check("req_addr", bus0.imem_req_addr, req_q.pop_front());
      end
      if (bus0.if_valid && bus0.if_ready) begin
        if (dec_q.size() == 0) begin
          check("unexpected_dec", bus0.if_inst, 32'hxxxx_xxxx);
        end else begin
          dec_t e;
          e = dec_q.pop_front();
          check("if_inst", bus0.if_inst, e.inst);
          check("if_pc", bus0.if_pc, e.pc);
          check("if_pc4", bus0.if_pc4, e.pc4);
        end
      end
    end
  end

  // Starts in REQ at addr; completes one fetch with hold cycles of decode backpressure.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] pc4, input int hold);
    req_q.push_back(addr);
    bus0.imem_req_ready = 1'b1;
    cyc();
    bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b1;
    bus0.imem_rsp_data  = data;
    dec_q.push_back('{inst: data, pc: addr, pc4: pc4});
    cyc();
    bus0.imem_rsp_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("hold_if_valid", {31'd0, bus0.if_valid}, 32'd1);
      check("hold_if_inst", bus0.if_inst, data);
      check("hold_if_pc", bus0.if_pc, addr);
      check("hold_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
      cyc();
    end
    bus0.if_ready = 1'b1;
    cyc();
    bus0.if_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus0.redirect = 1'b0; bus0.redirect_addr = '0; bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b0; bus0.imem_rsp_data = '0; bus0.if_ready = 1'b0;
    bus1.redirect = 1'b0; bus1.redirect_addr = '0; bus1.imem_req_ready = 1'b0;
    bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_data = '0; bus1.if_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset / IDLE outputs
    check("idle_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
    check("idle_if_valid", {31'd0, bus0.if_valid}, 32'd0);
    check("idle_if_inst", bus0.if_inst, 32'd0);
    check("idle_if_pc", bus0.if_pc, 32'd0);
    check("idle_if_pc4", bus0.if_pc4, 32'd4);
    cyc();
    check("first_req_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
    check("first_req_addr", bus0.imem_req_addr, 32'd0);

    // Basic fetch, then backpressure
    fetch(32'h0, 32'h0050_0093, 32'h4, 0);
    check("next_req_addr", bus0.imem_req_addr, 32'h4);
    fetch(32'h4, 32'h0010_0113, 32'h8, 3);
    check("after_hold_req_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
    check("after_hold_req_addr", bus0.imem_req_addr, 32'h8);

    // Redirect in WAIT before the response: drain, response discarded
    req_q.push_back(32'h8);
    bus0.imem_req_ready = 1'b1;
    cyc();
    bus0.imem_req_ready = 1'b0;
    bus0.redirect = 1'b1; bus0.redirect_addr = 32'h100;
    cyc();
    bus0.redirect = 1'b0;
    check("drain_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
    check("drain_if_valid", {31'd0, bus0.if_valid}, 32'd0);
    cyc();
    check("drain2_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
    bus0.imem_rsp_valid = 1'b1; bus0.imem_rsp_data = 32'hDEAD_0008;
    cyc();
    bus0.imem_rsp_valid = 1'b0;
    check("post_drain_req_addr", bus0.imem_req_addr, 32'h100);
    fetch(32'h100, 32'h0020_0193, 32'h104, 0);

    // Redirect coincident with response in WAIT
    req_q.push_back(32'h104);
    bus0.imem_req_ready = 1'b1;
    cyc();
    bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b1; bus0.imem_rsp_data = 32'hDEAD_0104;
    bus0.redirect = 1'b1; bus0.redirect_addr = 32'h200;
    cyc();
    bus0.imem_rsp_valid = 1'b0; bus0.redirect = 1'b0;
    check("wait_rd_req_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
    check("wait_rd_req_addr", bus0.imem_req_addr, 32'h200);
    check("wait_rd_if_valid", {31'd0, bus0.if_valid}, 32'd0);

    // Redirect coincident with acceptance in REQ
    req_q.push_back(32'h200);
    bus0.imem_req_ready = 1'b1;
    bus0.redirect = 1'b1; bus0.redirect_addr = 32'h300;
    cyc();
    bus0.imem_req_ready = 1'b0; bus0.redirect = 1'b0;
    check("req_rd_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
    bus0.imem_rsp_valid = 1'b1; bus0.imem_rsp_data = 32'hDEAD_0200;
    cyc();
    bus0.imem_rsp_valid = 1'b0;
    check("req_rd_req_addr", bus0.imem_req_addr, 32'h300);

    // Unaccepted redirect retargets the request; low address bits dropped
    bus0.redirect = 1'b1; bus0.redirect_addr = 32'h203;
    cyc();
    bus0.redirect = 1'b0;
    check("aligned_req_addr", bus0.imem_req_addr, 32'h200);
    fetch(32'h200, 32'h0030_0213, 32'h204, 0);

    // PC wrap through redirect
    bus0.redirect = 1'b1; bus0.redirect_addr = 32'hFFFF_FFFC;
    cyc();
    bus0.redirect = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h0040_0293, 32'h0, 0);
    check("wrap_req_addr", bus0.imem_req_addr, 32'h0);

    // Redirect in HOLD drops the buffered instruction
    req_q.push_back(32'h0);
    bus0.imem_req_ready = 1'b1;
    cyc();
    bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b1; bus0.imem_rsp_data = 32'h0050_0313;
    cyc();
    bus0.imem_rsp_valid = 1'b0;
    check("hold_valid_pre", {31'd0, bus0.if_valid}, 32'd1);
    bus0.redirect = 1'b1; bus0.redirect_addr = 32'h400;
    #1;
    check("hold_valid_rd", {31'd0, bus0.if_valid}, 32'd0);
    cyc();
    bus0.redirect = 1'b0;
    check("hold_rd_req_addr", bus0.imem_req_addr, 32'h400);

    // Reset in WAIT coincident with a response
    req_q.push_back(32'h400);
    bus0.imem_req_ready = 1'b1;
    cyc();
    bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b1; bus0.imem_rsp_data = 32'hDEAD_0400;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus0.imem_rsp_valid = 1'b0;
    check("rst_if_valid", {31'd0, bus0.if_valid}, 32'd0);
    check("rst_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
    check("rst_if_inst", bus0.if_inst, 32'd0);
    check("wrap_idle_if_pc", bus1.if_pc, 32'hFFFF_FFFC);
    check("wrap_idle_if_pc4", bus1.if_pc4, 32'h0);
    cyc();
    check("rst_req_addr", bus0.imem_req_addr, 32'h0);

    // Second instance: RESET_PC at the top of the address space
    check("wrap_first_req_addr", bus1.imem_req_addr, 32'hFFFF_FFFC);
    bus1.imem_req_ready = 1'b1;
    cyc();
    bus1.imem_req_ready = 1'b0;
    bus1.imem_rsp_valid = 1'b1; bus1.imem_rsp_data = 32'h0060_0393;
    cyc();
    bus1.imem_rsp_valid = 1'b0;
    check("wrap_if_valid", {31'd0, bus1.if_valid}, 32'd1);
    check("wrap_if_inst", bus1.if_inst, 32'h0060_0393);
    check("wrap_if_pc4", bus1.if_pc4, 32'h0);
    bus1.if_ready = 1'b1;
    cyc();
    bus1.if_ready = 1'b0;
    check("wrap_next_req_addr", bus1.imem_req_addr, 32'h0);

    cyc();
    check("req_queue_left", req_q.size(), 32'd0);
    check("dec_queue_left", dec_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
